// File: rtl/rv_wb_stage_pkg.sv
// rtl/rv_wb_stage_pkg.sv - shared datapath width and load funct3 encodings (RVX info)
package rv_wb_stage_pkg;

  localparam int RVX_BUS_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/rv_wb_stage_load_align.sv
// rtl/rv_wb_stage_load_align.sv - load lane extraction, extension and legality check
module rv_load_align
  import rv_wb_stage_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [RVX_BUS_W-1:0] rdata,
  output logic [RVX_BUS_W-1:0] data,
  output logic                 illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // pick the addressed byte / halfword lane, then extend by load type
  always_comb begin
    lane_b  = rdata[7:0];
    lane_h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    data    = '0;
    illegal = 1'b0;
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    case (funct3)
      F3_LB:  data = {{24{lane_b[7]}}, lane_b};
      F3_LBU: data = {24'd0, lane_b};
      F3_LH: begin
        illegal = addr_lo[0];
        data    = {{16{lane_h[15]}}, lane_h};
      end
      F3_LHU: begin
        illegal = addr_lo[0];
        data    = {16'd0, lane_h};
      end
      F3_LW: begin
        illegal = (addr_lo != 2'd0);
        data    = rdata;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv_wb_stage.sv
// rtl/rv_wb_stage.sv - writeback stage: ALU results and aligned loads into the regfile
module rv_wb_stage
  import rv_wb_stage_pkg::*;
#(
  parameter int BUS_W        = RVX_BUS_W,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic             in_rd_we,
  input  logic             in_is_load,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [BUS_W-1:0] in_alu_res,
  input  logic             dmem_rvalid,
  input  logic [BUS_W-1:0] dmem_rdata,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [BUS_W-1:0] rf_wdata,
  output logic             load_err,
  output logic [31:0]      retire_cnt
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  // last WAIT_LOAD cycle before giving up is the one where the counter would reach the limit
  localparam logic [31:0] TMO_LAST = 32'(LOAD_TIMEOUT - 1);

  state_t           state, state_next;
  logic [4:0]       ld_rd;
  logic             ld_rd_we;
  logic [2:0]       ld_funct3;
  logic [1:0]       ld_addr_lo;
  logic [31:0]      tmo_cnt;
  logic             tmo_hit;
  logic [BUS_W-1:0] ld_data;
  logic             ld_illegal;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  rv_load_align u_align (
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .rdata   (dmem_rdata),
    .data    (ld_data),
    .illegal (ld_illegal)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // next state and ready decode
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_is_load) state_next = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (dmem_rvalid || tmo_hit) state_next = IDLE;
      end
    endcase
  end

  // registered writeback, load context, timeout counter and retire count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= '0;
      load_err   <= 1'b0;
      retire_cnt <= 32'd0;
      tmo_cnt    <= 32'd0;
      ld_rd      <= 5'd0;
      ld_rd_we   <= 1'b0;
      ld_funct3  <= 3'd0;
      ld_addr_lo <= 2'd0;
    end else begin
      rf_we    <= 1'b0;
      load_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!in_is_load) begin
              retire_cnt <= retire_cnt + 32'd1;
              if (in_rd_we && (in_rd != 5'd0)) begin
                rf_we    <= 1'b1;
                rf_waddr <= in_rd;
                rf_wdata <= in_alu_res;
              end
            end else begin
              ld_rd      <= in_rd;
              ld_rd_we   <= in_rd_we;
              ld_funct3  <= in_funct3;
              ld_addr_lo <= in_addr_lo;
              tmo_cnt    <= 32'd0;
            end
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            retire_cnt <= retire_cnt + 32'd1;
            if (ld_illegal) begin
              load_err <= 1'b1;
            end else if (ld_rd_we && (ld_rd != 5'd0)) begin
              rf_we    <= 1'b1;
              rf_waddr <= ld_rd;
              rf_wdata <= ld_data;
            end
          end else if (tmo_hit) begin
            retire_cnt <= retire_cnt + 32'd1;
            load_err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_wb_stage.sv
// tb/tb_rv_wb_stage.sv - self-checking bench for rv_wb_stage
module tb_rv_wb_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = 5'd0;
  logic        in_rd_we = 1'b0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [1:0]  in_addr_lo = 2'd0;
  logic [31:0] in_alu_res = 32'd0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_err;
  logic [31:0] retire_cnt;

  int vectors = 0;
  int miscompares = 0;

  rv_wb_stage #(.BUS_W(32), .LOAD_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_alu_res(in_alu_res),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .load_err(load_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: what each retirement must produce, from the load rules
  logic        m_we = 1'b0, m_err = 1'b0, m_wait = 1'b0;
  logic [4:0]  m_waddr = 5'd0;
  logic [31:0] m_wdata = 32'd0, m_cnt = 32'd0;
  int          m_timer = 0;
  logic [4:0]  p_rd;
  logic        p_we;
  logic [2:0]  p_f3;
  logic [1:0]  p_lo;

  function automatic logic [32:0] m_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] sh;
    int v;
    sh = w >> (8 * lo);
    case (f3)
      3'b000: begin v = int'(sh & 32'hFF); if (v >= 128) v = v - 256; return {1'b0, 32'(v)}; end
      3'b100: return {1'b0, sh & 32'hFF};
      3'b001: begin
        if (lo[0]) return {1'b1, 32'd0};
        v = int'(sh & 32'hFFFF); if (v >= 32768) v = v - 65536; return {1'b0, 32'(v)};
      end
      3'b101: begin
        if (lo[0]) return {1'b1, 32'd0};
        return {1'b0, sh & 32'hFFFF};
      end
      3'b010: begin
        if (lo != 2'd0) return {1'b1, 32'd0};
        return {1'b0, w};
      end
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  task m_commit(input logic we, input logic [4:0] rd, input logic [31:0] val);
    m_cnt = m_cnt + 32'd1;
    if (we && rd != 5'd0) begin
      m_we = 1'b1; m_waddr = rd; m_wdata = val;
    end
  endtask

  // advance the model on every rising edge, resetting asynchronously
  always @(posedge clk or negedge rst) begin
    logic [32:0] r;
    if (!rst) begin
      m_we = 0; m_err = 0; m_wait = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_timer = 0;
    end else begin
      m_we = 0; m_err = 0;
      if (!m_wait) begin
        if (in_valid) begin
          if (in_is_load) begin
            m_wait = 1; m_timer = 0;
            p_rd = in_rd; p_we = in_rd_we; p_f3 = in_funct3; p_lo = in_addr_lo;
          end else begin
            m_commit(in_rd_we, in_rd, in_alu_res);
          end
        end
      end else if (dmem_rvalid) begin
        r = m_load(p_f3, p_lo, dmem_rdata);
        m_wait = 0;
        if (r[32]) begin m_err = 1; m_cnt = m_cnt + 32'd1; end
        else m_commit(p_we, p_rd, r[31:0]);
      end else begin
        m_timer++;
        if (m_timer >= TO) begin m_err = 1; m_cnt = m_cnt + 32'd1; m_wait = 0; end
      end
    end
  end

  // compare every output against the model on each falling edge
  always @(negedge clk) begin
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("load_err", {31'd0, load_err}, {31'd0, m_err});
    chk("retire_cnt", retire_cnt, m_cnt);
    chk("in_ready", {31'd0, in_ready}, {31'd0, ~m_wait});
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic ld, input logic [4:0] rd, input logic we,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu);
    in_valid = 1; in_is_load = ld; in_rd = rd; in_rd_we = we;
    in_funct3 = f3; in_addr_lo = lo; in_alu_res = alu;
    step();
    in_valid = 0; in_is_load = 0;
  endtask

  task automatic load_next(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    issue(1, rd, 1, f3, lo, 32'd0);
    dmem_rvalid = 1; dmem_rdata = w;
    step();
    dmem_rvalid = 0;
  endtask

  initial begin
    #3;
    chk("reset rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset rf_wdata", rf_wdata, 32'd0);
    chk("reset retire_cnt", retire_cnt, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    rst = 1;
    step();

    issue(0, 5'd5, 1, 3'd0, 2'd0, 32'h12345678);
    chk("alu rf_we", {31'd0, rf_we}, 32'd1);
    chk("alu waddr", {27'd0, rf_waddr}, 32'd5);
    chk("alu wdata", rf_wdata, 32'h12345678);
    chk("alu retire", retire_cnt, 32'd1);
    step();
    chk("alu pulse", {31'd0, rf_we}, 32'd0);
    issue(0, 5'd7, 0, 3'd0, 2'd0, 32'h0000DEAD);
    chk("nowrite hold", rf_wdata, 32'h12345678);

    issue(1, 5'd10, 1, 3'b000, 2'd3, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("lb wait ready", {31'd0, in_ready}, 32'd0);
      if (i < 3) step();
    end
    dmem_rvalid = 1; dmem_rdata = 32'h80FFFFFF;
    step();
    dmem_rvalid = 0;
    chk("lb wdata", rf_wdata, 32'hFFFFFF80);
    chk("lb waddr", {27'd0, rf_waddr}, 32'd10);
    chk("lb ready", {31'd0, in_ready}, 32'd1);

    load_next(5'd11, 3'b101, 2'd2, 32'hBEEF1234);
    chk("lhu wdata", rf_wdata, 32'h0000BEEF);
    load_next(5'd12, 3'b001, 2'd1, 32'hBEEF1234);
    chk("lh misalign err", {31'd0, load_err}, 32'd1);
    chk("lh misalign we", {31'd0, rf_we}, 32'd0);
    load_next(5'd12, 3'b010, 2'd2, 32'h11111111);
    chk("lw misalign err", {31'd0, load_err}, 32'd1);
    load_next(5'd12, 3'b011, 2'd0, 32'h11111111);
    chk("f3 011 err", {31'd0, load_err}, 32'd1);
    load_next(5'd13, 3'b010, 2'd0, 32'hCAFEF00D);
    chk("lw wdata", rf_wdata, 32'hCAFEF00D);
    load_next(5'd14, 3'b000, 2'd1, 32'h00007F00);
    chk("lb pos wdata", rf_wdata, 32'h0000007F);
    load_next(5'd14, 3'b100, 2'd0, 32'h000000FF);
    chk("lbu wdata", rf_wdata, 32'h000000FF);
    load_next(5'd14, 3'b001, 2'd2, 32'h80011234);
    chk("lh wdata", rf_wdata, 32'hFFFF8001);
    load_next(5'd0, 3'b010, 2'd0, 32'hFFFFFFFF);
    chk("rd0 we", {31'd0, rf_we}, 32'd0);
    chk("rd0 retire", retire_cnt, 32'd12);

    issue(1, 5'd14, 1, 3'b010, 2'd0, 32'd0);
    step(); step(); step();
    chk("timeout early", {31'd0, load_err}, 32'd0);
    step();
    chk("timeout err", {31'd0, load_err}, 32'd1);
    chk("timeout ready", {31'd0, in_ready}, 32'd1);
    chk("timeout retire", retire_cnt, 32'd13);

    issue(1, 5'd15, 1, 3'b010, 2'd0, 32'd0);
    step(); step(); step();
    dmem_rvalid = 1; dmem_rdata = 32'h11112222;
    step();
    dmem_rvalid = 0;
    chk("edge rvalid wdata", rf_wdata, 32'h11112222);
    chk("edge rvalid err", {31'd0, load_err}, 32'd0);

    dmem_rvalid = 1; dmem_rdata = 32'h55555555;
    step();
    dmem_rvalid = 0;
    chk("idle rvalid we", {31'd0, rf_we}, 32'd0);
    chk("idle rvalid retire", retire_cnt, 32'd14);

    issue(1, 5'd16, 1, 3'b010, 2'd0, 32'd0);
    step();
    #2 rst = 0;
    #1;
    chk("async rst wdata", rf_wdata, 32'd0);
    chk("async rst retire", retire_cnt, 32'd0);
    chk("async rst ready", {31'd0, in_ready}, 32'd1);
    step(); step();
    rst = 1;
    dmem_rvalid = 1; dmem_rdata = 32'hA5A5A5A5;
    step();
    dmem_rvalid = 0;
    chk("post rst we", {31'd0, rf_we}, 32'd0);
    chk("post rst wdata", rf_wdata, 32'd0);
    chk("post rst retire", retire_cnt, 32'd0);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
